// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - store FIFO in front of data_memory with load forwarding and drain arbitration
//
// Owns the single data_memory address port. Retiring stores are queued and
// written back when no load wants the port, or when a pending drain has lost
// STARVE_MAX cycles in a row. Loads that hit a queued store are forwarded from
// the youngest matching entry.
//
// Optional feature: define SB_COALESCE_EN to merge a store into the youngest
// entry when the addresses match (no new allocation).
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   st_valid/st_addr/st_data      store request from MEM stage
//   st_ready                      store accepted this cycle when st_valid
//   ld_req/ld_addr                load request from MEM stage
//   ld_data                       load result, same cycle (0 when no ld_req)
//   ld_stall                      load not serviced this cycle
//   sb_empty/sb_count             occupancy
//   mem_read/mem_write/mem_address/mem_write_data/mem_read_data  data_memory port
module store_buffer #(
    parameter int DEPTH      = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     st_valid,
    input  logic [ADDR_W-1:0]        st_addr,
    input  logic [DATA_W-1:0]        st_data,
    output logic                     st_ready,
    input  logic                     ld_req,
    input  logic [ADDR_W-1:0]        ld_addr,
    output logic [DATA_W-1:0]        ld_data,
    output logic                     ld_stall,
    output logic                     sb_empty,
    output logic [$clog2(DEPTH):0]   sb_count,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic [ADDR_W-1:0]        mem_address,
    output logic [DATA_W-1:0]        mem_write_data,
    input  logic [DATA_W-1:0]        mem_read_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [STV_W-1:0]  starve_q, starve_d;

    logic              empty;
    logic              full;
    logic              grant_drain;
    logic              coalesce_hit;
    logic              alloc;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic [PTR_W-1:0]  idx;

`ifdef SB_COALESCE_EN
    logic [PTR_W-1:0]  youngest;
    logic              overwrite;

    always_comb begin
        youngest = tail_q - PTR_W'(1);
        // Merging into the head while it is leaving would lose the new data,
        // so that case falls back to a normal allocation.
        coalesce_hit = !empty && (addr_q[youngest] == st_addr)
                       && !(grant_drain && (youngest == head_q));
        overwrite    = st_valid && !rst && coalesce_hit;
    end
`else
    assign coalesce_hit = 1'b0;
`endif

    always_comb begin
        // While rst is high the buffer is treated as already empty so the
        // outputs show the post-reset values immediately.
        empty       = rst || (count_q == '0);
        full        = (count_q == CNT_W'(DEPTH));
        grant_drain = !empty && (!ld_req || (starve_q == STV_W'(STARVE_MAX)));
        st_ready    = rst || !full || grant_drain || coalesce_hit;
        alloc       = st_valid && st_ready && !rst && !coalesce_hit;

        // Scan oldest to youngest so the last match wins.
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PTR_W'(i);
            if (!rst && (CNT_W'(i) < count_q) && (addr_q[idx] == ld_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[idx];
            end
        end

        mem_write      = grant_drain;
        mem_read       = ld_req && !grant_drain && !rst;
        mem_address    = grant_drain ? addr_q[head_q] : (mem_read ? ld_addr : '0);
        mem_write_data = grant_drain ? data_q[head_q] : '0;

        ld_stall = ld_req && grant_drain && !fwd_hit;
        ld_data  = !ld_req ? '0 : (fwd_hit ? fwd_data : mem_read_data);
        sb_empty = empty;
        sb_count = rst ? '0 : count_q;

        head_d  = head_q + PTR_W'(grant_drain);
        tail_d  = tail_q + PTR_W'(alloc);
        count_d = count_q + CNT_W'(alloc) - CNT_W'(grant_drain);

        starve_d = starve_q;
        if (grant_drain) begin
            starve_d = '0;
        end else if (ld_req && !empty && (starve_q != STV_W'(STARVE_MAX))) begin
            starve_d = starve_q + STV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            starve_q <= '0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            starve_q <= starve_d;
        end
    end

    // Entry storage needs no reset: occupancy is defined by count_q alone.
    always_ff @(posedge clk) begin
        if (alloc) begin
            addr_q[tail_q] <= st_addr;
            data_q[tail_q] <= st_data;
        end
`ifdef SB_COALESCE_EN
        if (overwrite) begin
            data_q[youngest] <= st_data;
        end
`endif
    end

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - self-checking bench for store_buffer
module tb_store_buffer;

`ifdef SB_COALESCE_EN
    localparam bit COAL = 1'b1;
`else
    localparam bit COAL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_ready;
    logic        ld_req;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic        ld_stall;
    logic        sb_empty;
    logic [2:0]  sb_count;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] wr_addr [$];
    logic [31:0] wr_data [$];

    always #5 clk = ~clk;

    // Memory contents are a fixed function of address: never-written words read 0x1000+addr.
    assign mem_read_data = mem_address + 32'h1000;

    always @(posedge clk) begin
        if (mem_write) begin
            wr_addr.push_back(mem_address);
            wr_data.push_back(mem_write_data);
        end
    end

    store_buffer dut (
        .clk            (clk),
        .rst            (rst),
        .st_valid       (st_valid),
        .st_addr        (st_addr),
        .st_data        (st_data),
        .st_ready       (st_ready),
        .ld_req         (ld_req),
        .ld_addr        (ld_addr),
        .ld_data        (ld_data),
        .ld_stall       (ld_stall),
        .sb_empty       (sb_empty),
        .sb_count       (sb_count),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    typedef struct {
        logic        st_valid;
        logic [31:0] st_addr;
        logic [31:0] st_data;
        logic        ld_req;
        logic [31:0] ld_addr;
        logic        e_st_ready;
        logic        e_ld_stall;
        logic [31:0] e_ld_data;
        logic [2:0]  e_count;
        logic        e_mem_write;
        logic        e_mem_read;
        logic [31:0] e_mem_address;
        logic [31:0] e_wdata;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic set_in(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                          input logic lr, input logic [31:0] la);
        st_valid = sv;
        st_addr  = sa;
        st_data  = sd;
        ld_req   = lr;
        ld_addr  = la;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base;
        int stalls;

        // Starvation and forwarding scenario, one vector per cycle.
        //          st_v  st_addr st_data  ld    ld_addr  rdy   stall ld_data    cnt   mw    mr    maddr    wdata
        vecs[0]  = '{1'b1, 32'd7,  32'hA,  1'b1, 32'd100, 1'b1, 1'b0, 32'h1064, 3'd0, 1'b0, 1'b1, 32'd100, 32'h0};
        vecs[1]  = '{1'b1, 32'd9,  32'hC,  1'b1, 32'd100, 1'b1, 1'b0, 32'h1064, 3'd1, 1'b0, 1'b1, 32'd100, 32'h0};
        vecs[2]  = '{1'b1, 32'd7,  32'hB,  1'b1, 32'd100, 1'b1, 1'b0, 32'h1064, 3'd2, 1'b0, 1'b1, 32'd100, 32'h0};
        vecs[3]  = '{1'b0, 32'd0,  32'h0,  1'b1, 32'd7,   1'b1, 1'b0, 32'hB,    3'd3, 1'b0, 1'b1, 32'd7,   32'h0};
        vecs[4]  = '{1'b0, 32'd0,  32'h0,  1'b1, 32'd7,   1'b1, 1'b0, 32'hB,    3'd3, 1'b1, 1'b0, 32'd7,   32'hA};
        vecs[5]  = '{1'b0, 32'd0,  32'h0,  1'b1, 32'd200, 1'b1, 1'b0, 32'h10C8, 3'd2, 1'b0, 1'b1, 32'd200, 32'h0};
        vecs[6]  = '{1'b0, 32'd0,  32'h0,  1'b1, 32'd200, 1'b1, 1'b0, 32'h10C8, 3'd2, 1'b0, 1'b1, 32'd200, 32'h0};
        vecs[7]  = '{1'b0, 32'd0,  32'h0,  1'b1, 32'd200, 1'b1, 1'b0, 32'h10C8, 3'd2, 1'b0, 1'b1, 32'd200, 32'h0};
        vecs[8]  = '{1'b0, 32'd0,  32'h0,  1'b1, 32'd200, 1'b1, 1'b1, 32'h1009, 3'd2, 1'b1, 1'b0, 32'd9,   32'hC};
        vecs[9]  = '{1'b0, 32'd0,  32'h0,  1'b0, 32'd0,   1'b1, 1'b0, 32'h0,    3'd1, 1'b1, 1'b0, 32'd7,   32'hB};
        vecs[10] = '{1'b0, 32'd0,  32'h0,  1'b1, 32'd200, 1'b1, 1'b0, 32'h10C8, 3'd0, 1'b0, 1'b1, 32'd200, 32'h0};
        vecs[11] = '{1'b1, 32'd30, 32'hD,  1'b0, 32'd0,   1'b1, 1'b0, 32'h0,    3'd0, 1'b0, 1'b0, 32'd0,   32'h0};
        vecs[12] = '{1'b0, 32'd0,  32'h0,  1'b1, 32'd200, 1'b1, 1'b0, 32'h10C8, 3'd1, 1'b0, 1'b1, 32'd200, 32'h0};
        vecs[13] = '{1'b0, 32'd0,  32'h0,  1'b1, 32'd200, 1'b1, 1'b0, 32'h10C8, 3'd1, 1'b0, 1'b1, 32'd200, 32'h0};
        vecs[14] = '{1'b0, 32'd0,  32'h0,  1'b1, 32'd200, 1'b1, 1'b0, 32'h10C8, 3'd1, 1'b0, 1'b1, 32'd200, 32'h0};
        vecs[15] = '{1'b0, 32'd0,  32'h0,  1'b1, 32'd200, 1'b1, 1'b1, 32'h101E, 3'd1, 1'b1, 1'b0, 32'd30,  32'hD};
        vecs[16] = '{1'b0, 32'd0,  32'h0,  1'b1, 32'd200, 1'b1, 1'b0, 32'h10C8, 3'd0, 1'b0, 1'b1, 32'd200, 32'h0};
        vecs[17] = '{1'b0, 32'd0,  32'h0,  1'b0, 32'd0,   1'b1, 1'b0, 32'h0,    3'd0, 1'b0, 1'b0, 32'd0,   32'h0};

        // Outputs while rst is held, with requests active.
        rst = 1'b1;
        set_in(1'b1, 32'd3, 32'h33, 1'b1, 32'd5);
        #1;
        chk("rst sb_empty", 32'(sb_empty), 32'd1);
        chk("rst sb_count", 32'(sb_count), 32'd0);
        chk("rst st_ready", 32'(st_ready), 32'd1);
        chk("rst mem_write", 32'(mem_write), 32'd0);
        chk("rst ld_stall", 32'(ld_stall), 32'd0);
        tick();
        rst = 1'b0;
        set_in(1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
        #1;
        chk("post-rst sb_count", 32'(sb_count), 32'd0);
        chk("post-rst sb_empty", 32'(sb_empty), 32'd1);
        tick();

        // Table-driven vectors.
        do_reset();
        base = wr_addr.size();
        for (int i = 0; i < NV; i++) begin
            set_in(vecs[i].st_valid, vecs[i].st_addr, vecs[i].st_data, vecs[i].ld_req, vecs[i].ld_addr);
            #1;
            chk($sformatf("v%0d st_ready", i), 32'(st_ready), 32'(vecs[i].e_st_ready));
            chk($sformatf("v%0d ld_stall", i), 32'(ld_stall), 32'(vecs[i].e_ld_stall));
            chk($sformatf("v%0d ld_data", i), ld_data, vecs[i].e_ld_data);
            chk($sformatf("v%0d sb_count", i), 32'(sb_count), 32'(vecs[i].e_count));
            chk($sformatf("v%0d sb_empty", i), 32'(sb_empty), 32'(vecs[i].e_count == 3'd0));
            chk($sformatf("v%0d mem_write", i), 32'(mem_write), 32'(vecs[i].e_mem_write));
            chk($sformatf("v%0d mem_read", i), 32'(mem_read), 32'(vecs[i].e_mem_read));
            chk($sformatf("v%0d mem_address", i), mem_address, vecs[i].e_mem_address);
            chk($sformatf("v%0d mem_write_data", i), mem_write_data, vecs[i].e_wdata);
            tick();
        end
        chk("table write count", 32'(wr_addr.size() - base), 32'd4);

        // Four stores with no loads drain in order on consecutive cycles.
        do_reset();
        base = wr_addr.size();
        for (int k = 1; k <= 4; k++) begin
            set_in(1'b1, 32'(k), 32'(10 * k), 1'b0, 32'd0);
            tick();
        end
        set_in(1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
        tick();
        #1;
        chk("drain4 sb_empty", 32'(sb_empty), 32'd1);
        chk("drain4 writes", 32'(wr_addr.size() - base), 32'd4);
        if (wr_addr.size() - base == 4) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("drain4 addr%0d", k), wr_addr[base + k], 32'(k + 1));
                chk($sformatf("drain4 data%0d", k), wr_data[base + k], 32'(10 * (k + 1)));
            end
        end
        tick();

        // Fill under continuous loads; the full buffer refuses stores until a drain wins.
        do_reset();
        base = wr_addr.size();
        for (int k = 0; k < 5; k++) begin
            set_in(1'b1, 32'(11 + k), 32'(32'h100 + k), 1'b1, 32'd300);
            #1;
            chk($sformatf("fill sb_count%0d", k), 32'(sb_count), 32'(k < 4 ? k : 4));
            if (k == 4) begin
                chk("fill full+drain st_ready", 32'(st_ready), 32'd1);
                chk("fill full+drain mem_write", 32'(mem_write), 32'd1);
            end
            tick();
        end
        set_in(1'b1, 32'd16, 32'h105, 1'b1, 32'd300);
        #1;
        chk("full sb_count", 32'(sb_count), 32'd4);
        chk("full st_ready", 32'(st_ready), 32'd0);
        stalls = 0;
        while (st_ready !== 1'b1 && stalls < 10) begin
            stalls++;
            tick();
            #1;
        end
        chk("full stall cycles", 32'(stalls), 32'd3);
        chk("full release mem_write", 32'(mem_write), 32'd1);
        tick();
        set_in(1'b0, 32'd0, 32'd0, 1'b1, 32'd300);
        #1;
        chk("full after sb_count", 32'(sb_count), 32'd4);
        chk("full writes", 32'(wr_addr.size() - base), 32'd2);
        if (wr_addr.size() - base == 2) begin
            chk("full wr0 addr", wr_addr[base], 32'd11);
            chk("full wr1 addr", wr_addr[base + 1], 32'd12);
            chk("full wr1 data", wr_data[base + 1], 32'h101);
        end

        // Reset with three stores pending discards them.
        do_reset();
        base = wr_addr.size();
        for (int k = 0; k < 3; k++) begin
            set_in(1'b1, 32'(20 + k), 32'(32'h200 + k), 1'b1, 32'd50);
            tick();
        end
        set_in(1'b1, 32'd23, 32'h99, 1'b1, 32'd50);
        #1;
        chk("pend sb_count", 32'(sb_count), 32'd3);
        rst = 1'b1;
        #1;
        chk("pend rst mem_write", 32'(mem_write), 32'd0);
        chk("pend rst ld_stall", 32'(ld_stall), 32'd0);
        tick();
        rst = 1'b0;
        set_in(1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
        #1;
        chk("pend post sb_count", 32'(sb_count), 32'd0);
        tick();
        tick();
        set_in(1'b0, 32'd0, 32'd0, 1'b1, 32'd20);
        #1;
        chk("pend load ld_data", ld_data, 32'h1014);
        chk("pend load mem_read", 32'(mem_read), 32'd1);
        chk("pend writes", 32'(wr_addr.size() - base), 32'd0);
        tick();

        // Same-address back-to-back stores under loads.
        do_reset();
        base = wr_addr.size();
        set_in(1'b1, 32'd5, 32'd1, 1'b1, 32'd60);
        tick();
        set_in(1'b1, 32'd5, 32'd2, 1'b1, 32'd60);
        tick();
        set_in(1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
        #1;
        chk("coal sb_count", 32'(sb_count), COAL ? 32'd1 : 32'd2);
        tick();
        tick();
        tick();
        chk("coal writes", 32'(wr_addr.size() - base), COAL ? 32'd1 : 32'd2);
        if (wr_addr.size() - base >= 1) begin
            chk("coal first data", wr_data[base], COAL ? 32'd2 : 32'd1);
            chk("coal last data", wr_data[wr_addr.size() - 1], 32'd2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
